// File: rtl/io_pkg.sv
// io_pkg: address map and field widths shared by the io_bridge slice
package io_pkg;
  localparam logic [31:0] ADDR_DIG     = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_LED     = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW      = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN     = 32'hFFFF_F078;
  localparam logic [31:0] ADDR_BTN_EVT = 32'hFFFF_F07C;
  localparam logic [19:0] IO_PAGE      = 20'hFFFFF;
  localparam int LED_W = 24;
  localparam int SW_W  = 24;
  localparam int BTN_W = 5;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchroniser plus stable-count debouncer for one button bit
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic diff, flip;
  assign diff = sync[1] ^ level;
  assign flip = diff & (cnt == LAST);
  assign rise = flip & sync[1];
  // synchronise the pin, count mismatch cycles and adopt the synced value once the window completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync  <= {sync[0], pin};
      cnt   <= (diff & ~flip) ? cnt + 1'b1 : '0;
      level <= flip ? sync[1] : level;
    end
  end
endmodule

// File: rtl/io_bridge.sv
// io_bridge: CPU memory-mapped bridge to DRAM, display, LEDs, switches and buttons; IO_BTN_EVT_EN enables sticky button events
module io_bridge
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic [31:0]       dram_addr,
  output logic              dram_we,
  output logic [31:0]       dram_wdata,
  input  logic [31:0]       dram_rdata,
  output logic              dig_we,
  output logic [31:0]       dig_wdata,
  output logic [LED_W-1:0]  led_out,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [BTN_W-1:0]  btn_in
);
  logic dram_hit, dig_hit, led_hit, sw_hit, btn_hit, evt_hit;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [BTN_W-1:0] btn_lvl, rise, evt;
  assign dram_hit   = cpu_addr[31:12] != IO_PAGE;
  assign dig_hit    = cpu_addr == ADDR_DIG;
  assign led_hit    = cpu_addr == ADDR_LED;
  assign sw_hit     = cpu_addr == ADDR_SW;
  assign btn_hit    = cpu_addr == ADDR_BTN;
  assign dram_addr  = cpu_addr;
  assign dram_wdata = cpu_wdata;
  assign dig_wdata  = cpu_wdata;
  assign dram_we    = cpu_we & dram_hit;
  assign dig_we     = cpu_we & dig_hit;
  genvar i;
  generate
    for (i = 0; i < BTN_W; i++) begin : g_btn
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk(clk), .rst(rst), .pin(btn_in[i]), .level(btn_lvl[i]), .rise(rise[i])
      );
    end
  endgenerate
`ifdef IO_BTN_EVT_EN
  assign evt_hit = cpu_addr == ADDR_BTN_EVT;
  // sticky press flags: write-1-to-clear, a simultaneous rise keeps the bit set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) evt <= '0;
    else     evt <= (evt & ~((cpu_we & evt_hit) ? cpu_wdata[BTN_W-1:0] : '0)) | rise;
  end
`else
  assign evt_hit = 1'b0;
  assign evt     = '0;
  wire unused_rise = ^rise;
`endif
  // LED register and switch synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
    end else begin
      led_out <= (cpu_we & led_hit) ? cpu_wdata[LED_W-1:0] : led_out;
      sw_s1   <= sw_in;
      sw_s2   <= sw_s1;
    end
  end
  // load data mux; unmapped and write-only addresses read zero
  always_comb begin
    cpu_rdata = dram_hit ? dram_rdata :
                led_hit  ? {{(32-LED_W){1'b0}}, led_out} :
                sw_hit   ? {{(32-SW_W){1'b0}}, sw_s2} :
                btn_hit  ? {{(32-BTN_W){1'b0}}, btn_lvl} :
                evt_hit  ? {{(32-BTN_W){1'b0}}, evt} : 32'h0;
  end
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed scoreboard bench for io_bridge with a 4-cycle debounce window
module tb_io_bridge;
  localparam logic [31:0] A_DIG = 32'hFFFF_F000;
  localparam logic [31:0] A_LED = 32'hFFFF_F060;
  localparam logic [31:0] A_SW  = 32'hFFFF_F070;
  localparam logic [31:0] A_BTN = 32'hFFFF_F078;
  localparam logic [31:0] A_EVT = 32'hFFFF_F07C;
`ifdef IO_BTN_EVT_EN
  localparam bit EVT_ON = 1'b1;
`else
  localparam bit EVT_ON = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dram_rdata = 0;
  logic cpu_we = 0;
  logic [31:0] cpu_rdata, dram_addr, dram_wdata, dig_wdata;
  logic dram_we, dig_we;
  logic [23:0] led_out, sw_in = 0;
  logic [4:0] btn_in = 0;
  logic [31:0] sb[$];
  int tests = 0, fails = 0;

  io_bridge #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .dig_we(dig_we), .dig_wdata(dig_wdata), .led_out(led_out),
    .sw_in(sw_in), .btn_in(btn_in)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %h with empty scoreboard", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    cpu_addr = a;
    cpu_we = 0;
    push(e);
    #1 check(tag, cpu_rdata);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_we = 1;
    step(1);
    cpu_we = 0;
  endtask

  initial begin
    step(1);
    push(32'h0); check("reset_led", {8'h0, led_out});
    rst = 0;
    step(1);
    rd("reset_btn", A_BTN, 32'h0);
    rd("reset_sw", A_SW, 32'h0);
    cpu_addr = A_DIG; cpu_wdata = 32'h1234_5678; cpu_we = 1;
    push(32'h1); #1 check("dig_we", {31'h0, dig_we});
    push(32'h1234_5678); check("dig_wdata", dig_wdata);
    push(32'h0); check("dig_dram_we", {31'h0, dram_we});
    step(1); cpu_we = 0;
    rd("dig_read", A_DIG, 32'h0);
    wr(A_LED, 32'h00AB_CDEF);
    push(32'h00AB_CDEF); check("led_out", {8'h0, led_out});
    rd("led_read", A_LED, 32'h00AB_CDEF);
    cpu_addr = 32'hFFFF_F004; cpu_wdata = 32'hFFFF_FFFF; cpu_we = 1;
    push(32'h0); #1 check("unmapped_strobes", {30'h0, dram_we, dig_we});
    step(1); cpu_we = 0;
    push(32'h00AB_CDEF); check("unmapped_led_kept", {8'h0, led_out});
    rd("unmapped_read", 32'hFFFF_F004, 32'h0);
    dram_rdata = 32'hDEAD_BEEF;
    rd("dram_read", 32'h0000_1000, 32'hDEAD_BEEF);
    cpu_wdata = 32'h0BAD_F00D; cpu_we = 1;
    push(32'h2); #1 check("dram_strobes", {30'h0, dram_we, dig_we});
    push(32'h0000_1000); check("dram_addr", dram_addr);
    push(32'h0BAD_F00D); check("dram_wdata", dram_wdata);
    step(1); cpu_we = 0;
    sw_in = 24'hA5A5A5;
    step(1);
    rd("sw_1edge", A_SW, 32'h0);
    step(1);
    rd("sw_2edge", A_SW, 32'h00A5_A5A5);
    btn_in[0] = 1;
    step(3);
    btn_in[0] = 0;
    step(10);
    rd("glitch_btn", A_BTN, 32'h0);
    rd("glitch_evt", A_EVT, 32'h0);
    btn_in[0] = 1;
    step(5);
    rd("btn_5edge", A_BTN, 32'h0);
    step(1);
    rd("btn_6edge", A_BTN, 32'h1);
    rd("evt_rise", A_EVT, EVT_ON ? 32'h1 : 32'h0);
    btn_in[2] = 1;
    step(6);
    rd("btn_two", A_BTN, 32'h5);
    rd("evt_two", A_EVT, EVT_ON ? 32'h5 : 32'h0);
    wr(A_EVT, 32'h1);
    rd("evt_clear", A_EVT, EVT_ON ? 32'h4 : 32'h0);
    btn_in[2] = 0;
    step(8);
    rd("btn2_low", A_BTN, 32'h1);
    btn_in[2] = 1;
    step(5);
    wr(A_EVT, 32'h4);
    rd("btn2_high", A_BTN, 32'h5);
    rd("evt_set_wins", A_EVT, EVT_ON ? 32'h4 : 32'h0);
    wr(A_LED, 32'h00FF_FFFF);
    push(32'h00FF_FFFF); check("led_full", {8'h0, led_out});
    btn_in[1] = 1;
    step(4);
    rst = 1;
    push(32'h0); #1 check("rst_led", {8'h0, led_out});
    rd("rst_btn", A_BTN, 32'h0);
    rd("rst_evt", A_EVT, 32'h0);
    rd("rst_sw", A_SW, 32'h0);
    step(1);
    rst = 0;
    step(5);
    rd("post_rst_5edge", A_BTN, 32'h0);
    step(1);
    rd("post_rst_6edge", A_BTN, 32'h7);
    rd("post_rst_evt", A_EVT, EVT_ON ? 32'h7 : 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
